sp_arbiter: RTL and testbench

SP_ARBITER -- requirements
Module: sp_arbiter

---
 rtl/sp_pkg.sv | 17 +
 rtl/rr_arb2.sv | 11 +
 rtl/sp_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sp_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared sizing and state encoding for the two-requester sample-processing arbiter.
package sp_pkg;
  localparam int SAMPLE_W     = 9;
  localparam int RESULT_W     = 10;
  localparam int MODE_W       = 3;
  localparam int FRAME_LEN    = 9;
  localparam int WAIT_TIMEOUT = 255;
  localparam int CNT_W        = $clog2(FRAME_LEN + 1);
  localparam int TMO_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: pure combinational pick of the next frame owner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       winner_id
);
  assign grant_valid = |req;
  // On contention the side that did not win last time goes next.
  assign winner_id   = (&req) ? ~last_owner : req[1];
endmodule

// File: rtl/sp_arbiter.sv
// Frame arbiter: grants one of two requesters, buffers a 9-sample frame, streams it to
// the engine and forwards three engine results (with timeout) back to the owner.
module sp_arbiter
  import sp_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_0,
  input  logic [MODE_W-1:0]          mode_0,
  output logic                       gnt_0,
  input  logic                       dat_vld_0,
  input  logic signed [SAMPLE_W-1:0] dat_0,
  input  logic                       req_1,
  input  logic [MODE_W-1:0]          mode_1,
  output logic                       gnt_1,
  input  logic                       dat_vld_1,
  input  logic signed [SAMPLE_W-1:0] dat_1,
  output logic                       sp_in_valid,
  output logic [SAMPLE_W-1:0]        sp_in_data,
  output logic [MODE_W-1:0]          sp_in_mode,
  input  logic                       sp_out_valid,
  input  logic signed [RESULT_W-1:0] sp_out_data,
  output logic                       res_valid,
  output logic                       res_id,
  output logic [RESULT_W-1:0]        res_data,
  output logic                       res_last,
  output logic                       busy,
  output logic                       err
);
  state_t              r_state, w_state_next;
  logic                r_owner, r_last_owner;
  logic [MODE_W-1:0]   r_mode;
  logic [SAMPLE_W-1:0] r_buf [FRAME_LEN];
  logic [CNT_W-1:0]    r_cnt;
  logic [TMO_W-1:0]    r_timer;
  logic [1:0]          r_rcnt;

  logic                r_gnt_0, r_gnt_1, r_sp_in_valid, r_res_valid, r_res_id, r_res_last;
  logic                r_busy, r_err;
  logic [SAMPLE_W-1:0] r_sp_in_data;
  logic [MODE_W-1:0]   r_sp_in_mode;
  logic [RESULT_W-1:0] r_res_data;

  logic                w_grant_valid, w_winner, w_own_vld;
  logic [SAMPLE_W-1:0] w_own_dat;
  logic                w_load_done, w_send_done, w_third, w_timeout, w_err;

  rr_arb2 u_rr (
    .req         ({req_1, req_0}),
    .last_owner  (r_last_owner),
    .grant_valid (w_grant_valid),
    .winner_id   (w_winner)
  );

  assign w_own_vld   = r_owner ? dat_vld_1 : dat_vld_0;
  assign w_own_dat   = r_owner ? dat_1 : dat_0;
  assign w_load_done = (r_state == LOAD) && w_own_vld && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_send_done = (r_state == SEND) && (r_cnt == CNT_W'(FRAME_LEN));
  assign w_third     = (r_state == WAIT) && sp_out_valid && (r_rcnt == 2'd2);
  assign w_timeout   = (r_state == WAIT) && (r_timer == TMO_W'(WAIT_TIMEOUT));
  // Timeout err is raised one count early so it lands while busy is still high.
  assign w_err = (sp_out_valid && (r_state != WAIT)) ||
                 (w_own_vld && ((r_state == SEND) || (r_state == WAIT))) ||
                 ((r_state == WAIT) && !w_third && (r_timer == TMO_W'(WAIT_TIMEOUT - 1)));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = LOAD;
      LOAD:    if (w_load_done) w_state_next = SEND;
      SEND:    if (w_send_done) w_state_next = WAIT;
      WAIT:    if (w_third || w_timeout) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_owner  <= 1'b1;
      r_mode        <= '0;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_rcnt        <= '0;
      for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= '0;
      r_gnt_0       <= 1'b0;
      r_gnt_1       <= 1'b0;
      r_sp_in_valid <= 1'b0;
      r_sp_in_data  <= '0;
      r_sp_in_mode  <= '0;
      r_res_valid   <= 1'b0;
      r_res_id      <= 1'b0;
      r_res_data    <= '0;
      r_res_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= (w_state_next != IDLE);
      r_err         <= w_err;
      r_gnt_0       <= 1'b0;
      r_gnt_1       <= 1'b0;
      r_sp_in_valid <= 1'b0;
      r_sp_in_data  <= '0;
      r_sp_in_mode  <= '0;
      r_res_valid   <= 1'b0;
      r_res_id      <= 1'b0;
      r_res_data    <= '0;
      r_res_last    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_mode       <= w_winner ? mode_1 : mode_0;
            r_gnt_0      <= ~w_winner;
            r_gnt_1      <= w_winner;
            r_cnt        <= '0;
          end
        end
        LOAD: begin
          if (w_own_vld) begin
            r_buf[r_cnt] <= w_own_dat;
            // The first word is issued on the transition so the stream aligns with SEND.
            if (w_load_done) begin
              r_cnt         <= CNT_W'(1);
              r_sp_in_valid <= 1'b1;
              r_sp_in_data  <= r_buf[0];
              r_sp_in_mode  <= r_mode;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        SEND: begin
          if (w_send_done) begin
            r_timer <= '0;
            r_rcnt  <= '0;
          end else begin
            r_sp_in_valid <= 1'b1;
            r_sp_in_data  <= r_buf[r_cnt];
            r_cnt         <= r_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          r_timer <= r_timer + TMO_W'(1);
          if (sp_out_valid) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_owner;
            r_res_data  <= sp_out_data;
            r_res_last  <= (r_rcnt == 2'd2);
            r_rcnt      <= r_rcnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_0       = r_gnt_0;
  assign gnt_1       = r_gnt_1;
  assign sp_in_valid = r_sp_in_valid;
  assign sp_in_data  = r_sp_in_data;
  assign sp_in_mode  = r_sp_in_mode;
  assign res_valid   = r_res_valid;
  assign res_id      = r_res_id;
  assign res_data    = r_res_data;
  assign res_last    = r_res_last;
  assign busy        = r_busy;
  assign err         = r_err;
endmodule

// File: tb/tb_sp_arbiter.sv
// Self-checking bench for sp_arbiter: frame table, reset/stray sequences and random frames
// checked against a frame-level round-robin model.
module tb_sp_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_0, req_1, dat_vld_0, dat_vld_1, sp_out_valid;
  logic [2:0] mode_0, mode_1;
  logic [8:0] dat_0, dat_1;
  logic [9:0] sp_out_data;
  logic       gnt_0, gnt_1, sp_in_valid, res_valid, res_id, res_last, busy, err;
  logic [8:0] sp_in_data;
  logic [2:0] sp_in_mode;
  logic [9:0] res_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_frame = 0;
  int model_last = 1;

  typedef struct {
    logic [1:0]       mask;
    logic [2:0]       m0;
    logic [2:0]       m1;
    int               base;
    int               nres;
    logic [2:0][9:0]  rv;
    int               exp_owner;
    int               stray;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  sp_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_0        (req_0),
    .mode_0       (mode_0),
    .gnt_0        (gnt_0),
    .dat_vld_0    (dat_vld_0),
    .dat_0        (dat_0),
    .req_1        (req_1),
    .mode_1       (mode_1),
    .gnt_1        (gnt_1),
    .dat_vld_1    (dat_vld_1),
    .dat_1        (dat_1),
    .sp_in_valid  (sp_in_valid),
    .sp_in_data   (sp_in_data),
    .sp_in_mode   (sp_in_mode),
    .sp_out_valid (sp_out_valid),
    .sp_out_data  (sp_out_data),
    .res_valid    (res_valid),
    .res_id       (res_id),
    .res_data     (res_data),
    .res_last     (res_last),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_dat(input int who, input logic v, input logic [8:0] d);
    if (who != 0) begin
      dat_vld_1 = v;
      dat_1     = d;
    end else begin
      dat_vld_0 = v;
      dat_0     = d;
    end
  endtask

  function automatic logic [2:0][9:0] mk3(input logic [9:0] a, input logic [9:0] b,
                                          input logic [9:0] c);
    logic [2:0][9:0] r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    return r;
  endfunction

  function automatic logic [29:0] all_outs();
    return {gnt_0, gnt_1, sp_in_valid, sp_in_data, sp_in_mode, res_valid, res_id,
            res_data, res_last, busy, err};
  endfunction

  // One whole frame from an IDLE cycle back to the next IDLE cycle.
  task automatic run_frame(input logic [1:0] mask, input logic [2:0] m0, input logic [2:0] m1,
                           input logic [8:0][8:0] samp, input int nres,
                           input logic [2:0][9:0] rv, input int owner, input int stray);
    int         e_cyc;
    int         gaps;
    logic [2:0] exp_mode;
    exp_mode = (owner != 0) ? m1 : m0;
    mode_0 = m0;
    mode_1 = m1;
    if (mask[0]) req_0 = 1'b1;
    if (mask[1]) req_1 = 1'b1;
    tick();
    chk("gnt", {gnt_1, gnt_0}, (owner != 0) ? 32'd2 : 32'd1);
    chk("busy_on_grant", busy, 1);
    if (owner != 0) req_1 = 1'b0;
    else req_0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        drive_dat(owner, 1'b0, 9'd0);
        drive_dat(1 - owner, 1'($urandom), 9'($urandom));
        tick();
        chk("load_gap_quiet", {gnt_1, gnt_0, sp_in_valid, err, ~busy}, 0);
      end
      drive_dat(owner, 1'b1, samp[k]);
      drive_dat(1 - owner, 1'($urandom), 9'($urandom));
      tick();
      if (k < 8) chk("load_quiet", {gnt_1, gnt_0, sp_in_valid, err, ~busy}, 0);
    end
    drive_dat(0, 1'b0, 9'd0);
    drive_dat(1, 1'b0, 9'd0);
    for (int k = 0; k < 9; k++) begin
      chk("send_valid", sp_in_valid, 1);
      chk("send_data", sp_in_data, samp[k]);
      chk("send_mode", sp_in_mode, (k == 0) ? exp_mode : 3'd0);
      chk("send_err", err, (k > 0 && stray == k - 1) ? 1 : 0);
      drive_dat(owner, (k == stray), 9'($urandom));
      tick();
      drive_dat(owner, 1'b0, 9'd0);
    end
    chk("wait_entry", {sp_in_valid, ~busy}, 0);
    chk("wait_entry_err", err, (stray == 8) ? 1 : 0);
    e_cyc = cyc;
    for (int i = 0; i < nres; i++) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        tick();
        chk("wait_gap", {res_valid, err}, 0);
      end
      sp_out_valid = 1'b1;
      sp_out_data  = rv[i];
      tick();
      sp_out_valid = 1'b0;
      sp_out_data  = 10'd0;
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, rv[i]);
      chk("res_id", res_id, owner);
      chk("res_last", res_last, (i == 2) ? 1 : 0);
      chk("busy_after_res", busy, (i < 2) ? 1 : 0);
      chk("res_err", err, 0);
    end
    if (nres < 3) begin
      while (cyc < e_cyc + 255) begin
        tick();
        chk("tmo_err", err, (cyc == e_cyc + 255) ? 1 : 0);
        chk("tmo_busy", busy, 1);
        chk("tmo_res", {res_valid, res_last}, 0);
      end
      tick();
      chk("tmo_release", {busy, err, res_last, res_valid}, 0);
    end
    n_frame++;
    $display("frame %0d: owner=%0d mode=%0d results=%0d stray=%0d", n_frame, owner,
             exp_mode, nres, stray);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0][8:0] s;
    logic [2:0][9:0] rv;
    logic [1:0]      mask, lvl;
    int              w, nres, stray;

    rst_n = 1'b0;
    {req_0, req_1, dat_vld_0, dat_vld_1, sp_out_valid} = '0;
    {mode_0, mode_1} = '0;
    {dat_0, dat_1} = '0;
    sp_out_data = '0;

    // Frame table: expected owners derived by hand from the round-robin rule.
    vt[0] = '{2'b11, 3'd0, 3'd0, 20,   3, mk3(10'd7, 10'd8, 10'd9),        0, -1};
    vt[1] = '{2'b10, 3'd0, 3'd2, -4,   3, mk3(10'h3ff, 10'd0, 10'd1),      1, -1};
    vt[2] = '{2'b11, 3'd7, 3'd1, 100,  3, mk3(10'h200, 10'h1ff, 10'd3),    0, 3};
    vt[3] = '{2'b10, 3'd0, 3'd5, -256, 3, mk3(10'd11, 10'd22, 10'd33),     1, -1};
    vt[4] = '{2'b01, 3'd0, 3'd0, 1,    3, mk3(10'd9, 10'd5, 10'd1),        0, -1};
    vt[5] = '{2'b01, 3'd4, 3'd0, 50,   2, mk3(10'd40, 10'h3f6, 10'd0),     0, -1};
    vt[6] = '{2'b11, 3'd3, 3'd6, -100, 3, mk3(10'd1, 10'd2, 10'd3),        1, 8};
    vt[7] = '{2'b01, 3'd2, 3'd0, 200,  3, mk3(10'h155, 10'h2aa, 10'd100),  0, -1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 0);

    // Stray engine result while idle.
    sp_out_valid = 1'b1;
    sp_out_data  = 10'd77;
    tick();
    sp_out_valid = 1'b0;
    sp_out_data  = 10'd0;
    chk("stray_out_err", err, 1);
    chk("stray_out_quiet", {res_valid, busy, sp_in_valid, sp_in_data}, 0);
    tick();
    chk("stray_out_err_clear", err, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 9; k++) s[k] = 9'(vt[r].base + k);
      run_frame(vt[r].mask, vt[r].m0, vt[r].m1, s, vt[r].nres, vt[r].rv, vt[r].exp_owner,
                vt[r].stray);
      model_last = vt[r].exp_owner;
    end

    // Reset in the middle of a load abandons the frame.
    req_0  = 1'b1;
    mode_0 = 3'd6;
    tick();
    chk("pre_reset_gnt", {gnt_1, gnt_0}, 2'b01);
    req_0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_dat(0, 1'b1, 9'(k + 1));
      tick();
      chk("pre_reset_load", {sp_in_valid, busy}, 2'b01);
    end
    drive_dat(0, 1'b0, 9'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_reset_quiet", all_outs(), 0);
    end
    model_last = 1;
    for (int k = 0; k < 9; k++) s[k] = 9'(30 - k);
    run_frame(2'b10, 3'd0, 3'd3, s, 3, mk3(10'd4, 10'd5, 10'd6), 1, -1);
    model_last = 1;

    // Random frames against the round-robin model.
    for (int f = 0; f < 25; f++) begin
      mask = 2'($urandom_range(1, 3));
      lvl  = {req_1, req_0} | mask;
      if (lvl == 2'b11) w = 1 - model_last;
      else w = lvl[1] ? 1 : 0;
      for (int k = 0; k < 9; k++) s[k] = 9'($urandom);
      for (int i = 0; i < 3; i++) rv[i] = 10'($urandom);
      nres = ($urandom_range(0, 7) == 0) ? 2 : 3;
      if ($urandom_range(0, 3) == 0) stray = $urandom_range(0, 8);
      else stray = -1;
      run_frame(mask, 3'($urandom), 3'($urandom), s, nres, rv, w, stray);
      model_last = w;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
